// File: rtl/sha_evt_source.sv
// sha_evt_source
//   Conditions SHA-256 completion pulses into a one-at-a-time, level-sensitive
//   request for the single-bit HPS interrupt PIO. Rising edges of done_i are
//   queued in a saturating pending counter. Software retires each event with a
//   high-then-low pulse on the PIO output bit, which comes back as ack_i.
//
//   Optional feature macro: SHA_EVT_TIMEOUT_EN
//     When defined, a watchdog counts consecutive cycles in the request state
//     and sets the sticky timeout_o after TIMEOUT_CYC cycles. When undefined,
//     no counter exists and timeout_o is tied to 0.
//
//   Ports
//     clk        in   system clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     done_i     in   SHA completion; each 0->1 is one event
//     ack_i      in   PIO acknowledge; each 0->1 retires one event
//     clr_i      in   synchronous clear of all state, highest priority
//     evt_o      out  registered request level to the PIO input bit
//     pending_o  out  registered pending-event count
//     overflow_o out  sticky: event arrived while the count was saturated
//     timeout_o  out  sticky: request left unacknowledged too long
module sha_evt_source #(
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             done_i,
  input  logic             ack_i,
  input  logic             clr_i,
  output logic             evt_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             overflow_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             done_q, ack_q;
  logic             done_rise, ack_rise, inc, dec;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    done_rise = done_i & ~done_q;
    ack_rise  = ack_i & ~ack_q;
    inc       = done_rise;
    // Acks are only meaningful while a request is visible; this also keeps
    // the count from ever decrementing below zero.
    dec       = ack_rise & (state_q == PEND);

    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    state_d = state_q;

    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end

    case (state_q)
      IDLE: if (inc) state_d = PEND;
      PEND: if (dec) state_d = HOLD;
      // Use the updated count so an event arriving on the release cycle is
      // not stranded in IDLE with a nonzero count.
      HOLD: if (!ack_i) state_d = (cnt_d != '0) ? PEND : IDLE;
      default: state_d = IDLE;
    endcase

    if (clr_i) begin
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = IDLE;
    end

    evt_d = (state_d == PEND);
  end

  // Edge flops sample even during clr_i, so an edge coinciding with a clear
  // is consumed and never seen afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q  <= done_i;
      ack_q   <= ack_i;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_o      = evt_q;
  assign pending_o  = cnt_q;
  assign overflow_o = ovf_q;

`ifdef SHA_EVT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;

  // Counts cycles spent in PEND; saturates so a long stall cannot wrap.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == PEND)
      tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    tmo_d = tmo_q | (tmo_cnt_d == TMO_MAX);
    if (clr_i) begin
      tmo_cnt_d = '0;
      tmo_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_sha_evt_source.sv
// Bench for sha_evt_source: directed vector table, hand sequences for
// overflow/clear/timeout/async reset, then random stimulus against an
// event-queue reference model.
module tb_sha_evt_source;
  localparam int CNT_W = 4;
  localparam int TMO   = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             done_i = 1'b0, ack_i = 1'b0, clr_i = 1'b0;
  logic             evt_o, overflow_o, timeout_o;
  logic [CNT_W-1:0] pending_o;

  sha_evt_source #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .done_i(done_i), .ack_i(ack_i),
    .clr_i(clr_i), .evt_o(evt_o), .pending_o(pending_o),
    .overflow_o(overflow_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Reference model: a queue depth, a "waiting for ack release" flag, and
  // the request is visible whenever events are queued and no release is due.
  int m_pend, m_wait;
  bit m_evt, m_hold, m_ovf, m_tmo, m_dp, m_ap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, want);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_wait = 0;
    m_evt = 0; m_hold = 0; m_ovf = 0; m_tmo = 0; m_dp = 0; m_ap = 0;
  endtask

  task automatic model_step(input bit d, input bit a, input bit c);
    bit dr, ar, ret;
    dr = d & !m_dp;
    ar = a & !m_ap;
    m_dp = d;
    m_ap = a;
    if (c) begin
      m_pend = 0; m_wait = 0; m_evt = 0; m_hold = 0; m_ovf = 0; m_tmo = 0;
    end else begin
      ret = ar && m_evt;
`ifdef SHA_EVT_TIMEOUT_EN
      m_wait = m_evt ? ((m_wait + 1 > TMO) ? TMO : m_wait + 1) : 0;
      if (m_wait == TMO) m_tmo = 1;
`endif
      if (dr && !ret && m_pend == MAXC) m_ovf = 1;
      else m_pend = m_pend + int'(dr) - int'(ret);
      if (ret) m_hold = 1;
      else if (m_hold && !a) m_hold = 0;
      m_evt = !m_hold && (m_pend > 0);
    end
  endtask

  task automatic cyc(input bit d, input bit a, input bit c);
    done_i = d; ack_i = a; clr_i = c;
    @(posedge clk);
    model_step(d, a, c);
    #1;
    chk("model_evt", evt_o, m_evt);
    chk("model_pend", pending_o, m_pend);
    chk("model_ovf", overflow_o, m_ovf);
    chk("model_tmo", timeout_o, m_tmo);
  endtask

  typedef struct {
    bit d, a, c;
    bit evt;
    int pend;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit d, input bit a, input bit c, input bit evt, input int pend);
    vec_t v;
    v.d = d; v.a = a; v.c = c; v.evt = evt; v.pend = pend;
    tbl.push_back(v);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_evt", evt_o, 0);
    chk("reset_pend", pending_o, 0);
    chk("reset_ovf", overflow_o, 0);
    chk("reset_tmo", timeout_o, 0);
    reset_n = 1'b1;

    // single event, ack held 3 cycles
    add(1,0,0, 1,1); add(0,0,0, 1,1);
    add(0,1,0, 0,0); add(0,1,0, 0,0); add(0,1,0, 0,0);
    add(0,0,0, 0,0); add(0,0,0, 0,0);
    // three events, three handshakes
    add(1,0,0, 1,1); add(0,0,0, 1,1); add(1,0,0, 1,2); add(0,0,0, 1,2);
    add(1,0,0, 1,3); add(0,0,0, 1,3);
    add(0,1,0, 0,2); add(0,0,0, 1,2);
    add(0,1,0, 0,1); add(0,0,0, 1,1);
    add(0,1,0, 0,0); add(0,0,0, 0,0); add(0,0,0, 0,0);
    // simultaneous done/ack rise in PEND at count 2
    add(1,0,0, 1,1); add(0,0,0, 1,1); add(1,0,0, 1,2); add(0,0,0, 1,2);
    add(1,1,0, 0,2); add(0,1,0, 0,2); add(0,0,0, 1,2);
    add(0,1,0, 0,1); add(0,0,0, 1,1); add(0,1,0, 0,0); add(0,0,0, 0,0);
    // ack in IDLE is ignored
    add(0,1,0, 0,0); add(0,0,0, 0,0);
    // done held high counts once
    add(1,0,0, 1,1); add(1,0,0, 1,1); add(1,0,0, 1,1); add(0,0,0, 1,1);
    add(0,1,0, 0,0); add(0,0,0, 0,0);

    foreach (tbl[i]) begin
      cyc(tbl[i].d, tbl[i].a, tbl[i].c);
      chk("tbl_evt", evt_o, tbl[i].evt);
      chk("tbl_pend", pending_o, tbl[i].pend);
      chk("tbl_ovf", overflow_o, 0);
    end

    // saturation and overflow, then clear with a coincident done edge
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 0);
      chk("sat_pend", pending_o, (i > MAXC) ? MAXC : i);
      chk("sat_ovf", overflow_o, (i == 16) ? 1 : 0);
      cyc(0, 0, 0);
    end
    cyc(1, 0, 1);
    chk("clr_pend", pending_o, 0);
    chk("clr_ovf", overflow_o, 0);
    chk("clr_evt", evt_o, 0);
    chk("clr_tmo", timeout_o, 0);
    cyc(1, 0, 0);
    chk("clr_edge_lost", pending_o, 0);
    cyc(0, 0, 0);

`ifdef SHA_EVT_TIMEOUT_EN
    cyc(1, 0, 0);
    chk("tmo_evt", evt_o, 1);
    for (int k = 1; k <= TMO; k++) begin
      cyc(0, 0, 0);
      chk("tmo_step", timeout_o, (k == TMO) ? 1 : 0);
    end
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("tmo_sticky", timeout_o, 1);
    cyc(0, 0, 1);
    chk("tmo_clr", timeout_o, 0);
`endif

    // asynchronous reset in the middle of PEND
    cyc(1, 0, 0);
    for (int k = 0; k < TMO + 2; k++) cyc(0, 0, 0);
    chk("pre_rst_evt", evt_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_evt", evt_o, 0);
    chk("arst_pend", pending_o, 0);
    chk("arst_ovf", overflow_o, 0);
    chk("arst_tmo", timeout_o, 0);
    model_reset();
    done_i = 0; ack_i = 0; clr_i = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(0, 0, 0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha_evt_source.md
# sha_evt_source

Event-conditioning stage directly upstream of the single-bit HPS interrupt PIO. It captures completion pulses from the SHA-256 core, queues them in a saturating pending counter, and presents one level-sensitive request per event on the PIO input bit. Software retires events one at a time by pulsing the PIO output bit high then low; that bit returns here as the acknowledge.

## Interface
- CNT_W, 4: width of the pending-event counter; maximum queued events is 2^CNT_W-1.
- TIMEOUT_CYC, 1024: cycles a request may stay unacknowledged before `timeout_o` sets. Used only with the timeout feature. Must be ≥1.

- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- done_i  in  1  SHA core completion. Each rising edge (0→1 across consecutive samples) is one event.
- ack_i  in  1  acknowledge from the PIO output bit. Each rising edge retires one event.
- clr_i  in  1  synchronous clear of all state. Has priority over every other input.
- evt_o  out  1  request level, wired to the PIO input bit. Registered.
- pending_o  out  CNT_W  current pending-event count. Registered.
- overflow_o  out  1  sticky; set when an event arrives while the count is saturated.
- timeout_o  out  1  sticky; request stayed unacknowledged too long. Constant 0 when the feature is compiled out.

## Operation
- Edge detection: `done_i` and `ack_i` each have a registered previous-value flop. Both flops reset to 0.
  - done_rise = done_i & ~done_q
  - ack_rise = ack_i & ~ack_q
- The FSM has three states; reset state is IDLE.
  - IDLE (count==0, evt_o=0):
    - done_rise → PEND.
    - ack_rise is ignored.
  - PEND (count>0, evt_o=1):
    - ack_rise → decrement count, go to HOLD.
  - HOLD (evt_o=0):
    - Wait for ack_i==0.
    - Then go to PEND if count>0, otherwise IDLE.
    - done_rise in HOLD increments the count but does not leave HOLD.
- Count update, every cycle:
  - inc = done_rise
  - dec = ack_rise while in PEND
  - inc & dec: count unchanged.
  - inc at all-ones with no dec: count holds and overflow_o sets.
  - dec is never applied at count 0. The FSM guarantees this.
- clr_i:
  - count → 0, state → IDLE.
  - overflow_o, timeout_o and the timeout counter → 0.
  - The edge flops still sample, so an edge coinciding with clr_i is discarded.
- Reset values: evt_o=0, pending_o=0, overflow_o=0, timeout_o=0.
  - Reset mid-operation discards all queued events immediately.

## Timing
- done_rise sampled at edge k: pending_o and evt_o update at edge k (1-cycle latency from the input change).
- ack_rise sampled at edge k in PEND: evt_o=0 after edge k.
- evt_o stays low for at least the cycles ack_i is held high.
- Earliest re-assertion: the edge after ack_i is sampled low, and only if count>0.
- Back-to-back done pulses need one low sample between them to count separately.
- A done_i held high for many cycles counts once.

## Configuration
- `SHA_EVT_TIMEOUT_EN` defined:
  - A counter of ceil(log2(TIMEOUT_CYC+1)) bits increments every cycle in PEND and clears in any other state.
  - When it reaches TIMEOUT_CYC, timeout_o sets at that edge and stays set until reset or clr_i.
- Undefined: no counter is instantiated and timeout_o is constant 0.

## Test plan
- Reset, then a single 1-cycle done pulse:
  - evt_o=1 and pending_o=1 one cycle later.
  - ack_i high 3 cycles → evt_o=0 for those 3 cycles.
  - ack_i low → IDLE, evt_o stays 0, pending_o=0.
- Three done pulses spaced 2 cycles apart, then three ack high/low handshakes:
  - pending_o steps 3→2→1→0.
  - evt_o re-asserts after the first two ack-low samples; after the third it stays 0.
- Default CNT_W=4, 16 done pulses with no ack:
  - pending_o=15 and overflow_o=1.
  - Pulse clr_i → pending_o=0, overflow_o=0, evt_o=0.
- Simultaneous done_rise and ack_rise in PEND with pending_o=2:
  - pending_o stays 2 and state goes to HOLD.
- ack_rise while in IDLE: no change (pending_o=0, evt_o=0).
- With `SHA_EVT_TIMEOUT_EN` and TIMEOUT_CYC=8:
  - One event with no ack → timeout_o=1 exactly 8 cycles after evt_o rises.
  - A reset asserted mid-PEND clears all outputs asynchronously.
